// File: rtl/keypad_scan_entry.sv
// 4x4 active-low hex keypad scanner with debounce, valid/ready key stream and 16-bit entry register.
// Define KEYPAD_REPEAT_EN to add auto-repeat while a key is held (period REPEAT_TICKS scan ticks).
module keypad_scan_entry #(
  parameter int SCAN_DIV_W     = 13,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int REPEAT_TICKS   = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic        key_valid,
  output logic [3:0]  key_code,
  input  logic        key_ready,
  output logic        key_overflow,
  input  logic        value_clr,
  output logic [15:0] value
);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2
  } state_t;

  localparam logic [3:0] DB_LIM = 4'(DEBOUNCE_TICKS);

  state_t                state_reg, state_next;
  logic [3:0]            row_meta_reg, row_sync_reg;
  logic [SCAN_DIV_W-1:0] div_reg;
  logic [1:0]            col_idx_reg, col_idx_next;
  logic [1:0]            row_idx_reg, row_idx_next;
  logic [3:0]            cnt_reg, cnt_next;
  logic [1:0]            low_idx;
  logic                  tick, any_low, latched_low, emit;
  logic [3:0]            emit_code;

`ifdef KEYPAD_REPEAT_EN
  localparam int               REP_W   = $clog2(REPEAT_TICKS + 1);
  localparam logic [REP_W-1:0] REP_LIM = REP_W'(REPEAT_TICKS);
  logic [REP_W-1:0] rep_reg, rep_next;
`else
  logic [31:0] repeat_unused;
  assign repeat_unused = 32'(REPEAT_TICKS);
`endif

  assign tick        = &div_reg;
  assign col         = ~(4'b0001 << col_idx_reg);
  assign any_low     = ~&row_sync_reg;
  assign latched_low = ~row_sync_reg[row_idx_reg];
  // Column is frozen whenever a key is emitted, so the live column index is the key's column.
  assign emit_code   = {row_idx_next, col_idx_reg};

  always_comb begin
    low_idx = 2'd3;
    if (!row_sync_reg[0])      low_idx = 2'd0;
    else if (!row_sync_reg[1]) low_idx = 2'd1;
    else if (!row_sync_reg[2]) low_idx = 2'd2;
  end

  always_comb begin
    state_next   = state_reg;
    col_idx_next = col_idx_reg;
    row_idx_next = row_idx_reg;
    cnt_next     = cnt_reg;
    emit         = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_next     = rep_reg;
`endif
    if (tick) begin
      case (state_reg)
        SCAN: begin
          if (any_low) begin
            row_idx_next = low_idx;
            if (DB_LIM <= 4'd1) begin
              emit       = 1'b1;
              state_next = HOLD;
              cnt_next   = 4'd0;
            end else begin
              state_next = DEBOUNCE;
              cnt_next   = 4'd1;
            end
          end else begin
            col_idx_next = col_idx_reg + 2'd1;
          end
`ifdef KEYPAD_REPEAT_EN
          rep_next = '0;
`endif
        end
        DEBOUNCE: begin
          if (latched_low) begin
            if (cnt_reg + 4'd1 >= DB_LIM) begin
              emit       = 1'b1;
              state_next = HOLD;
              cnt_next   = 4'd0;
            end else begin
              cnt_next = cnt_reg + 4'd1;
            end
          end else begin
            state_next   = SCAN;
            col_idx_next = col_idx_reg + 2'd1;
            cnt_next     = 4'd0;
          end
`ifdef KEYPAD_REPEAT_EN
          rep_next = '0;
`endif
        end
        HOLD: begin
          // In HOLD the counter tracks consecutive released ticks.
          if (!latched_low) begin
            if (cnt_reg + 4'd1 >= DB_LIM) begin
              state_next   = SCAN;
              col_idx_next = col_idx_reg + 2'd1;
              cnt_next     = 4'd0;
            end else begin
              cnt_next = cnt_reg + 4'd1;
            end
`ifdef KEYPAD_REPEAT_EN
            rep_next = '0;
`endif
          end else begin
            cnt_next = 4'd0;
`ifdef KEYPAD_REPEAT_EN
            if (rep_reg + REP_W'(1) == REP_LIM) begin
              emit     = 1'b1;
              rep_next = '0;
            end else begin
              rep_next = rep_reg + REP_W'(1);
            end
`endif
          end
        end
        default: begin
          state_next = SCAN;
          cnt_next   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_reg <= 4'hF;
      row_sync_reg <= 4'hF;
      div_reg      <= '0;
      state_reg    <= SCAN;
      col_idx_reg  <= 2'd0;
      row_idx_reg  <= 2'd0;
      cnt_reg      <= 4'd0;
`ifdef KEYPAD_REPEAT_EN
      rep_reg      <= '0;
`endif
    end else begin
      row_meta_reg <= row;
      row_sync_reg <= row_meta_reg;
      div_reg      <= div_reg + SCAN_DIV_W'(1);
      state_reg    <= state_next;
      col_idx_reg  <= col_idx_next;
      row_idx_reg  <= row_idx_next;
      cnt_reg      <= cnt_next;
`ifdef KEYPAD_REPEAT_EN
      rep_reg      <= rep_next;
`endif
    end
  end

  // A key emitted while the previous one is still pending is dropped but still shifted into value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_valid    <= 1'b0;
      key_code     <= 4'd0;
      key_overflow <= 1'b0;
      value        <= 16'h0000;
    end else begin
      if (emit && (!key_valid || key_ready)) begin
        key_code  <= emit_code;
        key_valid <= 1'b1;
      end else begin
        if (emit)                  key_overflow <= 1'b1;
        if (key_valid && key_ready) key_valid    <= 1'b0;
      end
      if (value_clr)
        value <= emit ? {12'h000, emit_code} : 16'h0000;
      else if (emit)
        value <= {value[11:0], emit_code};
    end
  end

endmodule

// File: tb/tb_keypad_scan_entry.sv
// Scoreboard bench for keypad_scan_entry: directed key presses against a modelled keypad matrix.
module tb_keypad_scan_entry;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready = 1'b0;
  logic        key_overflow;
  logic        value_clr = 1'b0;
  logic [15:0] value;

  logic        pressed = 1'b0;
  logic [1:0]  pr_row = 2'd0;
  logic [1:0]  pr_col = 2'd0;
  logic [1:0]  tb_div;

  logic [19:0] exp_q[$];
  logic [19:0] mon_exp;
  int          n_vec = 0;
  int          n_miss = 0;
  int          n_xfer = 0;

  always #5 clk = ~clk;

  keypad_scan_entry #(
    .SCAN_DIV_W    (2),
    .DEBOUNCE_TICKS(2),
    .REPEAT_TICKS  (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .row         (row),
    .col         (col),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_ready   (key_ready),
    .key_overflow(key_overflow),
    .value_clr   (value_clr),
    .value       (value)
  );

  // Keypad matrix: a pressed key pulls its row low only while its column is strobed.
  always_comb begin
    row = 4'hF;
    if (pressed && col[pr_col] == 1'b0) row[pr_row] = 1'b0;
  end

  // Scan tick occurs on the edge where this counter is 3 beforehand.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_div <= 2'd0;
    else        tb_div <= tb_div + 2'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && key_valid && key_ready) begin
      n_xfer++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_key: got code %h value %h, expected none", key_code, value);
      end else begin
        mon_exp = exp_q.pop_front();
        $display("xfer code=%h value=%h (expected code=%h value=%h)",
                 key_code, value, mon_exp[19:16], mon_exp[15:0]);
        check("xfer_code", 32'(key_code), 32'(mon_exp[19:16]));
        check("xfer_value", 32'(value), 32'(mon_exp[15:0]));
      end
    end
  end

  task automatic wait_tick();
    @(posedge clk iff tb_div == 2'd3);
  endtask

  task automatic wait_col(input logic [1:0] c);
    bit found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      wait_tick();
      #1;
      if (col == ~(4'b0001 << c)) found = 1'b1;
    end
    check("col_reached", 32'(found), 32'd1);
  endtask

  // Press when the column has just been strobed: detect next tick, emit on the one after.
  task automatic type_key(input logic [1:0] r, input logic [1:0] c, input bit clr);
    wait_col(c);
    pr_row  = r;
    pr_col  = c;
    pressed = 1'b1;
    wait_tick();
    if (clr) begin
      @(posedge clk iff tb_div == 2'd2);
      #1 value_clr = 1'b1;
      wait_tick();
      #1 value_clr = 1'b0;
    end else begin
      wait_tick();
      #1;
    end
    check("key_valid_on_emit", 32'(key_valid), 32'd1);
    pressed = 1'b0;
    wait_tick();
    wait_tick();
    #1;
  endtask

  logic [3:0]  seq_code [5] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
  logic [15:0] seq_val  [5] = '{16'h0091, 16'h0912, 16'h9123, 16'h1234, 16'h2345};
  logic [3:0]  walk     [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
  int          xfer_before;
  int          exp_rep;

  initial begin
    // Asynchronous reset asserted mid-cycle.
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_col", 32'(col), 32'(4'b1110));
    check("rst_key_valid", 32'(key_valid), 32'd0);
    check("rst_value", 32'(value), 32'h0000);
    check("rst_overflow", 32'(key_overflow), 32'd0);
    check("rst_key_code", 32'(key_code), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      wait_tick();
      #1;
      check("col_walk", 32'(col), 32'(walk[i]));
    end

    // Press key 9 (row 2, column 1).
    key_ready = 1'b1;
    exp_q.push_back({4'h9, 16'h0009});
    type_key(2'd2, 2'd1, 1'b0);
    check("resume_col2", 32'(col), 32'(4'b1011));
    check("valid_dropped", 32'(key_valid), 32'd0);

    // Single-tick bounce on row 0, column 0.
    wait_col(2'd0);
    pr_row  = 2'd0;
    pr_col  = 2'd0;
    pressed = 1'b1;
    wait_tick();
    #1 pressed = 1'b0;
    check("bounce_col_frozen", 32'(col), 32'(4'b1110));
    wait_tick();
    #1;
    check("bounce_col_advance", 32'(col), 32'(4'b1101));
    check("bounce_value", 32'(value), 32'h0009);
    check("bounce_no_valid", 32'(key_valid), 32'd0);

    // Entry sequence 1..5.
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({seq_code[i], seq_val[i]});
      type_key(seq_code[i][3:2], seq_code[i][1:0], 1'b0);
    end
    check("entry_value", 32'(value), 32'h2345);

    // Clear coincident with the emit of key 6.
    exp_q.push_back({4'h6, 16'h0006});
    type_key(2'd1, 2'd2, 1'b1);
    check("clr_with_emit", 32'(value), 32'h0006);
    @(posedge clk);
    #1 value_clr = 1'b1;
    @(posedge clk);
    #1 value_clr = 1'b0;
    check("clr_alone", 32'(value), 32'h0000);

    // Backpressure: key 3 held pending, key 7 dropped.
    key_ready = 1'b0;
    exp_q.push_back({4'h3, 16'h0037});
    type_key(2'd0, 2'd3, 1'b0);
    check("bp_first_code", 32'(key_code), 32'h3);
    check("bp_first_value", 32'(value), 32'h0003);
    type_key(2'd1, 2'd3, 1'b0);
    check("bp_code_held", 32'(key_code), 32'h3);
    check("bp_overflow", 32'(key_overflow), 32'd1);
    check("bp_value", 32'(value), 32'h0037);
    @(posedge clk);
    #1 key_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_valid_drop", 32'(key_valid), 32'd0);
    check("bp_overflow_sticky", 32'(key_overflow), 32'd1);

    // Hold key A for 14 ticks after acceptance.
`ifdef KEYPAD_REPEAT_EN
    exp_q.push_back({4'hA, 16'h037A});
    exp_q.push_back({4'hA, 16'h37AA});
    exp_q.push_back({4'hA, 16'h7AAA});
    exp_q.push_back({4'hA, 16'hAAAA});
    exp_rep = 4;
`else
    exp_q.push_back({4'hA, 16'h037A});
    exp_rep = 1;
`endif
    xfer_before = n_xfer;
    wait_col(2'd2);
    pr_row  = 2'd2;
    pr_col  = 2'd2;
    pressed = 1'b1;
    wait_tick();
    wait_tick();
    repeat (14) wait_tick();
    #1 pressed = 1'b0;
    repeat (3) wait_tick();
    #1;
    check("repeat_emits", 32'(n_xfer - xfer_before), 32'(exp_rep));
`ifdef KEYPAD_REPEAT_EN
    check("repeat_value", 32'(value), 32'hAAAA);
`else
    check("repeat_value", 32'(value), 32'h037A);
`endif

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 400000");
    $fatal(1);
  end

endmodule
